// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the data-memory responder
package mem_resp_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - DEPTH x 32 storage, one synchronous write port, one read port
// Not reset: contents persist across clear. The read value is captured by the responder on the accept edge.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency load/store responder for the core data-memory port
// Optional MEM_RESP_ERR_EN: out-of-range addresses suppress stores and return rsp_err instead of wrapping.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  rsp_t              rsp;
  logic              accept;
  logic              addr_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

`ifdef MEM_RESP_ERR_EN
  assign addr_err = (req_addr >= WORD_W'(DEPTH));
`else
  logic unused_addr_hi;
  assign addr_err       = 1'b0;
  assign unused_addr_hi = ^req_addr[WORD_W-1:AW];
`endif

  // Clear blocks the accept so no store can slip into the array while held in reset.
  assign accept = req_valid && (state == IDLE) && !clear;
  assign mem_we = accept && req_we && !addr_err;

  mem_resp_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (req_addr[AW-1:0]),
    .wdata(req_wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      rsp   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt       <= (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
        rsp.rdata <= (req_we || addr_err) ? '0 : mem_rdata;
        rsp.err   <= addr_err;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed checks of mem_responder against a word-array model
// Expectations follow MEM_RESP_ERR_EN when the bench is built with it.
module tb_mem_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        clear;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        u1_req_valid, u1_req_ready, u1_req_we;
  logic [31:0] u1_req_addr, u1_req_wdata;
  logic        u1_rsp_valid, u1_rsp_ready, u1_rsp_err;
  logic [31:0] u1_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk      (clk),
    .clear    (clear),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_lat1 (
    .clk      (clk),
    .clear    (clear),
    .req_valid(u1_req_valid),
    .req_ready(u1_req_ready),
    .req_we   (u1_req_we),
    .req_addr (u1_req_addr),
    .req_wdata(u1_req_wdata),
    .rsp_valid(u1_rsp_valid),
    .rsp_ready(u1_rsp_ready),
    .rsp_rdata(u1_rsp_rdata),
    .rsp_err  (u1_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_is_err(input logic [31:0] addr);
`ifdef MEM_RESP_ERR_EN
    return addr >= DEPTH;
`else
    return (addr == 32'hFFFF_FFFF) && (addr < DEPTH);
`endif
  endfunction

  // One full transaction: model update, latency, held response under backpressure, return to IDLE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, output logic [31:0] got);
    int          edges;
    logic        exp_e;
    logic [31:0] exp_d;
    exp_e = addr_is_err(addr);
    exp_d = (we || exp_e) ? 32'h0 : ref_mem[addr % DEPTH];
    if (we && !exp_e) ref_mem[addr % DEPTH] = wdata;

    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", edges, LAT);
    check("rsp_rdata", rsp_rdata, exp_d);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_e});
    got = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_done_valid", {31'b0, rsp_valid}, 32'd0);
    check("rsp_done_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic        seen;
    logic [31:0] mem1 [4];
    logic [31:0] exp_q [$];
    int          accepts, b2b, n;
    logic        prev_ready;

    clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    u1_req_valid = 1'b0; u1_req_we = 1'b0; u1_req_addr = '0; u1_req_wdata = '0; u1_rsp_ready = 1'b0;
    #12;
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    clear = 1'b0;

    for (int i = 0; i < DEPTH; i++) txn(1'b1, i, $urandom, 0, got);

    txn(1'b1, 32'd3, 32'hDEADBEEF, 0, got);
    txn(1'b0, 32'd3, 32'h0, 0, got);
    check("store_then_load", got, 32'hDEADBEEF);

    txn(1'b1, 32'd1, 32'h12345678, 0, got);
    txn(1'b0, 32'd1, 32'h0, 5, got);
    check("backpressure_load", got, 32'h12345678);

    txn(1'b0, 32'd35, 32'h0, 0, got);
    txn(1'b1, 32'd35, 32'hCAFEF00D, 0, got);
    txn(1'b0, 32'd3, 32'h0, 0, got);
`ifdef MEM_RESP_ERR_EN
    check("store35_mem3", got, 32'hDEADBEEF);
`else
    check("store35_mem3", got, 32'hCAFEF00D);
`endif

    // Asynchronous clear while a response is pending.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd1; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 10 && rsp_valid !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    check("pre_clear_valid", {31'b0, rsp_valid}, 32'd1);
    #2 clear = 1'b1;
    #1;
    check("async_req_ready", {31'b0, req_ready}, 32'd1);
    check("async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("async_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // Clear while waiting: the accepted store stays committed, its response is dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h1; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clear = 1'b1;
    ref_mem[7] = 32'h1;
    @(negedge clk);
    clear = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("clear_wait_no_rsp", {31'b0, seen}, 32'd0);
    txn(1'b0, 32'd7, 32'h0, 0, got);
    check("clear_wait_store_kept", got, 32'h1);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, DEPTH - 1);
      txn(1'b1 & $urandom_range(0, 1), a, $urandom, $urandom_range(0, 3), got);
    end

    // LATENCY=1 instance: requests held valid, one accept every two cycles.
    accepts = 0; b2b = 0; n = 0; prev_ready = 1'b0;
    u1_rsp_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (u1_rsp_valid === 1'b1) begin
        if (exp_q.size() > 0) begin
          check("lat1_rdata", u1_rsp_rdata, exp_q[0]);
          check("lat1_err", {31'b0, u1_rsp_err}, 32'd0);
          void'(exp_q.pop_front());
        end else begin
          check("lat1_spurious_rsp", 32'd1, 32'd0);
        end
      end
      if (u1_req_ready === 1'b1) begin
        if (prev_ready) b2b++;
        accepts++;
        u1_req_valid = 1'b1;
        if (n < 4) begin
          mem1[n] = $urandom;
          u1_req_we = 1'b1; u1_req_addr = n; u1_req_wdata = mem1[n];
          exp_q.push_back(32'h0);
        end else begin
          u1_req_we = 1'b0; u1_req_addr = n % 4; u1_req_wdata = $urandom;
          exp_q.push_back(mem1[n % 4]);
        end
        n++;
      end
      prev_ready = (u1_req_ready === 1'b1);
    end
    u1_req_valid = 1'b0;
    check("lat1_accepts", accepts, 32'd12);
    check("lat1_back_to_back", b2b, 32'd0);
    check("lat1_all_responded", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
